// File: rtl/seg7_scan_driver_if.sv
// Display-status bundle from the CPU core to the 7-segment scan driver.
// The core drives it through master; the scan driver reads it through slave.
interface seg7_scan_driver_if;
    logic [7:0] inp;
    logic       busy;
    logic       inp_take;
    logic       pc_disp;

    modport master (output inp, output busy, output inp_take, output pc_disp);
    modport slave  (input  inp, input  busy, input  inp_take, input  pc_disp);
endinterface

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode 7-seg scanner: mode glyph plus 3 BCD digits from a double-dabble engine.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros of hundreds/tens.
module seg7_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_driver_if.slave    disp,
    output logic [6:0]           led,
    output logic                 d1,
    output logic                 d2,
    output logic                 d3,
    output logic                 d4,
    output logic [7:0]           s_led
);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} conv_state_t;

    conv_state_t        r_state;
    conv_state_t        w_state_next;
    logic               w_load;
    logic               w_shift;
    logic               w_commit;
    logic               w_src_diff;

    logic [7:0]         r_src;
    logic [7:0]         r_sh;
    logic [11:0]        r_acc;
    logic [11:0]        w_acc_adj;
    logic [2:0]         r_it;
    logic [11:0]        r_bcd;

    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [1:0]         r_dig_idx;
    logic [6:0]         r_led;
    logic [3:0]         r_dig_en;
    logic [6:0]         w_led_next;
    logic [6:0]         w_mode_glyph;
    logic               w_blank_h;
    logic               w_blank_t;

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink;
    logic [7:0]         r_s_led;

    function automatic logic [6:0] f_digit_glyph(input logic [3:0] code);
        case (code)
            4'd0:    f_digit_glyph = 7'h40;
            4'd1:    f_digit_glyph = 7'h79;
            4'd2:    f_digit_glyph = 7'h24;
            4'd3:    f_digit_glyph = 7'h30;
            4'd4:    f_digit_glyph = 7'h19;
            4'd5:    f_digit_glyph = 7'h12;
            4'd6:    f_digit_glyph = 7'h02;
            4'd7:    f_digit_glyph = 7'h78;
            4'd8:    f_digit_glyph = 7'h00;
            4'd9:    f_digit_glyph = 7'h10;
            default: f_digit_glyph = 7'h7F;
        endcase
    endfunction

    assign w_src_diff = (disp.inp != r_src);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_src_diff) w_state_next = ST_SHIFT;
            ST_SHIFT:  if (r_it == 3'd7) w_state_next = ST_COMMIT;
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            ST_IDLE:   w_load   = w_src_diff;
            ST_SHIFT:  w_shift  = 1'b1;
            ST_COMMIT: w_commit = 1'b1;
            default:   w_load   = 1'b0;
        endcase
    end

    // Add-3 correction on every BCD nibble before each shift.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dabble
            assign w_acc_adj[gi*4 +: 4] = (r_acc[gi*4 +: 4] >= 4'd5) ?
                                          r_acc[gi*4 +: 4] + 4'd3 : r_acc[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_src <= 8'd0;
            r_sh  <= 8'd0;
            r_acc <= 12'd0;
            r_it  <= 3'd0;
            r_bcd <= 12'd0;
        end else begin
            if (w_load) begin
                r_src <= disp.inp;
                r_sh  <= disp.inp;
                r_acc <= 12'd0;
                r_it  <= 3'd0;
            end
            if (w_shift) begin
                r_acc <= {w_acc_adj[10:0], r_sh[7]};
                r_sh  <= {r_sh[6:0], 1'b0};
                r_it  <= r_it + 3'd1;
            end
            if (w_commit) r_bcd <= r_acc;
        end
    end

    always_comb begin
        w_mode_glyph = 7'h7F;
        if (disp.inp_take)     w_mode_glyph = 7'b1001111;
        else if (disp.pc_disp) w_mode_glyph = 7'b0001100;
        else if (disp.busy)    w_mode_glyph = 7'b0111111;
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign w_blank_h = (r_bcd[11:8] == 4'd0);
    assign w_blank_t = (r_bcd[11:4] == 8'd0);
`else
    assign w_blank_h = 1'b0;
    assign w_blank_t = 1'b0;
`endif

    always_comb begin
        w_led_next = 7'h7F;
        case (r_dig_idx)
            2'd0: w_led_next = w_mode_glyph;
            2'd1: w_led_next = w_blank_h ? 7'h7F : f_digit_glyph(r_bcd[11:8]);
            2'd2: w_led_next = w_blank_t ? 7'h7F : f_digit_glyph(r_bcd[7:4]);
            2'd3: w_led_next = f_digit_glyph(r_bcd[3:0]);
            default: w_led_next = 7'h7F;
        endcase
    end

    // Segments and enables register together so a digit never shows its neighbour's pattern.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_dig_idx  <= 2'd0;
            r_led      <= 7'h7F;
            r_dig_en   <= 4'hF;
        end else begin
            if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_dig_idx  <= r_dig_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_led    <= w_led_next;
            r_dig_en <= ~(4'b1000 >> r_dig_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
            r_s_led     <= 8'h00;
        end else if (!disp.inp_take) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
            r_s_led     <= disp.inp;
        end else begin
            if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
            r_s_led <= {8{r_blink}};
        end
    end

    assign led              = r_led;
    assign {d1, d2, d3, d4} = r_dig_en;
    assign s_led            = r_s_led;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a cycle-level behavioural model.
// Define LEADING_ZERO_BLANK_EN for both DUT and bench to cover the blanking build.
module tb_seg7_scan_driver;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] led;
    logic       d1, d2, d3, d4;
    logic [7:0] s_led;

    seg7_scan_driver_if disp_if ();

    seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .disp  (disp_if.slave),
        .led   (led),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .d4    (d4),
        .s_led (s_led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: edges since reset, pending conversion source/countdown, shown value, blink age.
    int m_n, m_src, m_cnt, m_val, m_k;
    logic [6:0] e_led;
    logic [3:0] e_dig;
    logic [7:0] e_sled;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 30)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] digit_glyph(input int d);
        case (d)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
            4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
            8: return 7'h00; 9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] slot_glyph(input int slot, input int val);
        int h, t, u;
        h = val / 100;
        t = (val / 10) % 10;
        u = val % 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot == 1 && h == 0) return 7'h7F;
        if (slot == 2 && val < 10) return 7'h7F;
`endif
        if (slot == 1) return digit_glyph(h);
        if (slot == 2) return digit_glyph(t);
        return digit_glyph(u);
    endfunction

    function automatic logic [6:0] mode_glyph(input logic take, input logic pc, input logic bsy);
        if (take) return 7'h4F;
        if (pc)   return 7'h0C;
        if (bsy)  return 7'h3F;
        return 7'h7F;
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        int slot;
        @(posedge clk);
        if (!rst_n) begin
            m_n = 0; m_src = 0; m_cnt = 0; m_val = 0; m_k = 0;
            e_led = 7'h7F; e_dig = 4'hF; e_sled = 8'h00;
        end else begin
            slot = (m_n / SCAN_DIV) % 4;
            m_n++;
            case (slot)
                0: e_dig = 4'b0111;
                1: e_dig = 4'b1011;
                2: e_dig = 4'b1101;
                default: e_dig = 4'b1110;
            endcase
            e_led = (slot == 0) ? mode_glyph(disp_if.inp_take, disp_if.pc_disp, disp_if.busy)
                                : slot_glyph(slot, m_val);
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_val = m_src;
            end else if (int'(disp_if.inp) != m_src) begin
                m_src = int'(disp_if.inp);
                m_cnt = 9;
            end
            if (disp_if.inp_take) begin
                e_sled = ((m_k / BLINK_DIV) % 2 == 1) ? 8'hFF : 8'h00;
                m_k++;
            end else begin
                e_sled = disp_if.inp;
                m_k = 0;
            end
        end
        #1;
        chk("led", 32'(led), 32'(e_led));
        chk("digit_en", 32'({d1, d2, d3, d4}), 32'(e_dig));
        chk("s_led", 32'(s_led), 32'(e_sled));
    endtask

    task automatic apply(input string label, input logic [7:0] v, input logic bsy,
                         input logic pc, input logic take, input int cycles);
        int e0;
        e0 = n_errors;
        disp_if.inp      = v;
        disp_if.busy     = bsy;
        disp_if.pc_disp  = pc;
        disp_if.inp_take = take;
        for (int i = 0; i < cycles; i++) step();
        $display("txn %-8s inp=%02h busy=%0b pc=%0b take=%0b cycles=%0d new_errors=%0d",
                 label, v, bsy, pc, take, cycles, n_errors - e0);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) step();
        rst_n = 1'b1;
        $display("txn reset    cycles=%0d", cycles);
    endtask

    initial begin
        logic [7:0] v;
        disp_if.inp      = 8'd0;
        disp_if.busy     = 1'b0;
        disp_if.pc_disp  = 1'b0;
        disp_if.inp_take = 1'b0;

        do_reset(3);
        apply("scan", 8'd0, 1'b0, 1'b0, 1'b0, 20);
        apply("max", 8'd255, 1'b0, 1'b0, 1'b0, 40);
        apply("retrig1", 8'd9, 1'b0, 1'b0, 1'b0, 3);
        apply("retrig2", 8'd200, 1'b0, 1'b0, 1'b0, 40);
        apply("busy", 8'd200, 1'b1, 1'b0, 1'b0, 20);
        apply("pc", 8'd200, 1'b1, 1'b1, 1'b0, 20);
        apply("take", 8'd200, 1'b1, 1'b1, 1'b1, 20);
        apply("idle", 8'd200, 1'b0, 1'b0, 1'b0, 20);
        apply("blink", 8'hA5, 1'b0, 1'b0, 1'b1, 40);
        apply("unblink", 8'hA5, 1'b0, 1'b0, 1'b0, 3);
        apply("seven", 8'd7, 1'b0, 1'b0, 1'b0, 40);
        apply("midrst", 8'd123, 1'b0, 1'b0, 1'b0, 4);
        do_reset(2);
        apply("after", 8'd123, 1'b0, 1'b0, 1'b0, 30);

        v = 8'd123;
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
            if ($urandom_range(0, 3) != 0) v = 8'($urandom_range(0, 255));
            apply("rand", v, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                  $urandom_range(1, 24));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
